// File: rtl/memory_responder_pkg.sv
// Shared memory-bus types for the memory responder.
// Holds the request/response bundles, the command and access-size
// encodings, the responder FSM state type, and the alignment helper used
// by both the lane aligner and anything else that needs the same rule.
package memory_responder_pkg;

    // Command: anything other than M_XWR is serviced as a read.
    typedef enum logic [1:0] {
        M_X   = 2'd0,
        M_XRD = 2'd1,
        M_XWR = 2'd2
    } MemoryWriteSignal;

    // Access size/sign; encodings outside this list are serviced as MT_W.
    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd4,
        MT_HU = 3'd5
    } MemoryMaskType;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        MemoryWriteSignal fcn;
        MemoryMaskType    typ;
    } MemoryReq;

    typedef struct packed {
        logic     req_valid;
        MemoryReq req;
    } MemoryIn;

    typedef struct packed {
        logic [31:0] data;
    } MemoryResp;

    typedef struct packed {
        logic      res_valid;
        MemoryResp res;
    } MemoryOut;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT,
        RS_RESP
    } ResponderState;

    // Latency counter width; covers LATENCY up to 15.
    localparam int unsigned CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    // Bytes are always aligned; halfwords need addr[0]==0; words (and any
    // unknown size, which is treated as a word) need addr[1:0]==0.
    function automatic logic mt_is_misaligned(MemoryMaskType typ, logic [1:0] addr_lo);
        case (typ)
            MT_B, MT_BU: return 1'b0;
            MT_H, MT_HU: return addr_lo[0];
            default:     return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bundle between a core memory port (master) and the
// memory responder (slave).
//   mem_in  : request valid + addr/data/fcn/typ      (master -> slave)
//   mem_out : response valid + read data             (slave -> master)
//   mem_err : misaligned-access flag, valid with res (slave -> master)
interface memory_responder_if;
    import memory_responder_pkg::*;

    MemoryIn  mem_in;
    MemoryOut mem_out;
    logic     mem_err;

    modport master (output mem_in, input mem_out, input mem_err);
    modport slave  (input mem_in, output mem_out, output mem_err);

endinterface

// File: rtl/memory_responder_lane_align.sv
// Big-endian lane steering for one 32-bit memory word (combinational).
// Ports:
//   typ        access size/sign (unknown values behave as MT_W)
//   addr_lo    byte offset within the word
//   rdata_word word read from the array
//   wdata      raw store data from the request (right-justified)
//   ext_rdata  read result, sign/zero extended; 0 when misaligned
//   wmask      per-byte write enables, bit k covers word bits [8k+7:8k]
//   wdata_word store data replicated onto every lane
//   misaligned access violates its natural alignment
module mem_lane_align
    import memory_responder_pkg::*;
(
    input  MemoryMaskType typ,
    input  logic [1:0]    addr_lo,
    input  logic [31:0]   rdata_word,
    input  logic [31:0]   wdata,
    output logic [31:0]   ext_rdata,
    output logic [3:0]    wmask,
    output logic [31:0]   wdata_word,
    output logic          misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        // Byte 0 is the most significant byte of the word.
        case (addr_lo)
            2'd0:    rbyte = rdata_word[31:24];
            2'd1:    rbyte = rdata_word[23:16];
            2'd2:    rbyte = rdata_word[15:8];
            default: rbyte = rdata_word[7:0];
        endcase
        rhalf      = addr_lo[1] ? rdata_word[15:0] : rdata_word[31:16];
        misaligned = mt_is_misaligned(typ, addr_lo);

        case (typ)
            MT_B: begin
                ext_rdata  = {{24{rbyte[7]}}, rbyte};
                wmask      = 4'b1000 >> addr_lo;
                wdata_word = {4{wdata[7:0]}};
            end
            MT_BU: begin
                ext_rdata  = {24'd0, rbyte};
                wmask      = 4'b1000 >> addr_lo;
                wdata_word = {4{wdata[7:0]}};
            end
            MT_H: begin
                ext_rdata  = {{16{rhalf[15]}}, rhalf};
                wmask      = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata_word = {2{wdata[15:0]}};
            end
            MT_HU: begin
                ext_rdata  = {16'd0, rhalf};
                wmask      = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata_word = {2{wdata[15:0]}};
            end
            default: begin
                ext_rdata  = rdata_word;
                wmask      = 4'b1111;
                wdata_word = wdata;
            end
        endcase

        // A misaligned access neither returns data nor touches the array.
        if (misaligned) begin
            ext_rdata = '0;
            wmask     = '0;
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Word-organised scratchpad that answers one core memory port.
// One request is accepted at a time; its response appears LATENCY cycles
// after acceptance. A new request may be accepted in the response cycle,
// so LATENCY=1 gives one response per cycle.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; drops any pending request
//   bus    memory_responder_if slave: mem_in request, mem_out response,
//          mem_err misalignment flag
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               reset,
    memory_responder_if.slave  bus
);

    localparam int unsigned ADDR_BITS = $clog2(DEPTH_WORDS);
    localparam cnt_t        CNT_INIT  = cnt_t'(LATENCY - 1);

    ResponderState state, state_nxt;
    cnt_t          cnt;
    MemoryReq      req_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic                 accept;
    logic                 resp;
    logic                 is_wr;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          rdata_word;
    logic [31:0]          ext_rdata;
    logic [31:0]          wdata_word;
    logic [3:0]           wmask;
    logic                 misaligned;

    // Requests are only looked at when the FSM can take one.
    assign accept = bus.mem_in.req_valid && (state == RS_IDLE || state == RS_RESP);
    // A reset landing on the response cycle suppresses the response and the write.
    assign resp   = (state == RS_RESP) && !reset;
    assign is_wr  = (req_q.fcn == M_XWR);

    // Upper address bits wrap silently.
    assign idx        = req_q.addr[ADDR_BITS+1:2];
    assign rdata_word = mem[idx];

    logic unused_addr;
    assign unused_addr = ^req_q.addr[31:ADDR_BITS+2];

    // State register, latency counter and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RS_IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= CNT_INIT;
                req_q <= bus.mem_in.req;
            end else if (state == RS_WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next state.
    always_comb begin
        state_nxt = state;
        case (state)
            RS_IDLE, RS_RESP: begin
                if (bus.mem_in.req_valid)
                    state_nxt = (LATENCY == 1) ? RS_RESP : RS_WAIT;
                else
                    state_nxt = RS_IDLE;
            end
            RS_WAIT: begin
                if (cnt == cnt_t'(1))
                    state_nxt = RS_RESP;
            end
            default: state_nxt = RS_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.mem_out = '0;
        bus.mem_err = 1'b0;
        if (resp) begin
            bus.mem_out.res_valid = 1'b1;
            bus.mem_err           = misaligned;
            if (!is_wr && !misaligned)
                bus.mem_out.res.data = ext_rdata;
        end
    end

    mem_lane_align u_align (
        .typ        (req_q.typ),
        .addr_lo    (req_q.addr[1:0]),
        .rdata_word (rdata_word),
        .wdata      (req_q.data),
        .ext_rdata  (ext_rdata),
        .wmask      (wmask),
        .wdata_word (wdata_word),
        .misaligned (misaligned)
    );

    // Byte-enabled write in the response cycle; wmask is already zero for
    // misaligned accesses.
    always_ff @(posedge clk) begin
        if (resp && is_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b])
                    mem[idx][8*b +: 8] <= wdata_word[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: one instance at LATENCY=2 and one
// at LATENCY=1. Each request pushes its expected data, error flag and
// response cycle; a negedge monitor pops and compares every response.
module tb_memory_responder;
    import memory_responder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    memory_responder_if bus2 ();
    memory_responder_if bus1 ();

    memory_responder #(.DEPTH_WORDS(4096), .LATENCY(2), .INIT_FILE("")) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    memory_responder #(.DEPTH_WORDS(256), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
    } exp_t;

    exp_t q2[$];
    exp_t q1[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitors.
    always @(negedge clk) begin
        exp_t e;
        if (bus2.mem_out.res_valid === 1'b1) begin
            if (q2.size() == 0) begin
                check("l2_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("l2_data",  bus2.mem_out.res.data, e.data);
                check("l2_err",   32'(bus2.mem_err), 32'(e.err));
                check("l2_cycle", 32'(cyc), 32'(e.at));
            end
        end else if (bus2.mem_err === 1'b1) begin
            check("l2_err_without_valid", 32'(bus2.mem_err), 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.mem_out.res_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("l1_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("l1_data",  bus1.mem_out.res.data, e.data);
                check("l1_err",   32'(bus1.mem_err), 32'(e.err));
                check("l1_cycle", 32'(cyc), 32'(e.at));
            end
        end else if (bus1.mem_err === 1'b1) begin
            check("l1_err_without_valid", 32'(bus1.mem_err), 32'd0);
        end
    end

    // Drive one request in the cycle after the next rising edge; it is
    // accepted at the end of that cycle and answered LATENCY cycles later.
    // With hold=1 req_valid stays high so the next call streams behind it.
    task automatic send(input bit lat1, input MemoryWriteSignal fcn, input MemoryMaskType typ,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_data, input logic exp_err, input bit hold);
        MemoryIn m;
        exp_t    e;
        @(posedge clk);
        #1;
        m.req_valid = 1'b1;
        m.req.addr  = addr;
        m.req.data  = data;
        m.req.fcn   = fcn;
        m.req.typ   = typ;
        e.data      = exp_data;
        e.err       = exp_err;
        if (lat1) begin
            bus1.mem_in = m;
            e.at        = cyc + 1;
            q1.push_back(e);
        end else begin
            bus2.mem_in = m;
            e.at        = cyc + 2;
            q2.push_back(e);
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            if (lat1) bus1.mem_in.req_valid = 1'b0;
            else      bus2.mem_in.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++)
            @(posedge clk);
        repeat (3) @(negedge clk);
        check("l2_pending_at_end", 32'(q2.size()), 32'd0);
        check("l1_pending_at_end", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        exp_t e;

        bus1.mem_in = '0;
        bus2.mem_in = '0;

        // Reset held for 3 cycles while a store to 0x10 is already offered.
        bus2.mem_in.req_valid = 1'b1;
        bus2.mem_in.req.addr  = 32'h10;
        bus2.mem_in.req.data  = 32'h11223344;
        bus2.mem_in.req.fcn   = M_XWR;
        bus2.mem_in.req.typ   = MT_W;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_valid_l2", 32'(bus2.mem_out.res_valid), 32'd0);
            check("rst_err_l2",   32'(bus2.mem_err), 32'd0);
            check("rst_valid_l1", 32'(bus1.mem_out.res_valid), 32'd0);
            check("rst_data_l2",  bus2.mem_out.res.data, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        e.data = 32'd0; e.err = 1'b0; e.at = cyc + 2;
        q2.push_back(e);
        @(posedge clk);
        #1;
        bus2.mem_in.req_valid = 1'b0;

        // Lane selection and extension.
        send(0, M_XRD, MT_BU, 32'h11, 32'h0,  32'h00000022, 1'b0, 0);
        send(0, M_XWR, MT_B,  32'h13, 32'h80, 32'h00000000, 1'b0, 0);
        send(0, M_XRD, MT_B,  32'h13, 32'h0,  32'hFFFFFF80, 1'b0, 0);
        send(0, M_XRD, MT_HU, 32'h10, 32'h0,  32'h00001122, 1'b0, 0);
        send(0, M_XRD, MT_H,  32'h12, 32'h0,  32'h00003380, 1'b0, 0);
        send(0, M_XWR, MT_H,  32'h12, 32'h8001, 32'h0,      1'b0, 0);
        send(0, M_XRD, MT_H,  32'h12, 32'h0,  32'hFFFF8001, 1'b0, 0);
        send(0, M_XRD, MT_W,  32'h10, 32'h0,  32'h11228001, 1'b0, 0);

        // Byte merge.
        send(0, M_XWR, MT_W,  32'h20, 32'hAABBCCDD, 32'h0,  1'b0, 0);
        send(0, M_XWR, MT_B,  32'h22, 32'h5A,       32'h0,  1'b0, 0);
        send(0, M_XRD, MT_W,  32'h20, 32'h0, 32'hAABB5ADD,  1'b0, 0);

        // Misaligned accesses complete with an error and leave the array alone.
        send(0, M_XRD, MT_W,  32'h22, 32'h0,    32'h0, 1'b1, 0);
        send(0, M_XWR, MT_H,  32'h21, 32'hFFFF, 32'h0, 1'b1, 0);
        send(0, M_XWR, MT_W,  32'h23, 32'h0,    32'h0, 1'b1, 0);
        send(0, M_XRD, MT_W,  32'h20, 32'h0, 32'hAABB5ADD, 1'b0, 0);

        // Address wrap-around.
        send(0, M_XWR, MT_W,  32'h4000, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        send(0, M_XRD, MT_W,  32'h0,    32'h0, 32'hCAFEF00D, 1'b0, 0);
        send(0, M_XRD, MT_BU, 32'h4003, 32'h0, 32'h0000000D, 1'b0, 0);

        // Reset during WAIT drops the pending store.
        send(0, M_XWR, MT_W,  32'h40, 32'h0BADBEEF, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        bus2.mem_in.req_valid = 1'b1;
        bus2.mem_in.req.addr  = 32'h40;
        bus2.mem_in.req.data  = 32'h12345678;
        bus2.mem_in.req.fcn   = M_XWR;
        bus2.mem_in.req.typ   = MT_W;
        @(posedge clk);
        #1;
        bus2.mem_in.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, M_XRD, MT_W,  32'h40, 32'h0, 32'h0BADBEEF, 1'b0, 0);

        // LATENCY=1 streaming: 8 stores then 8 loads with req_valid held.
        for (int i = 0; i < 8; i++)
            send(1, M_XWR, MT_W, 32'(4 * i), 32'hA5000000 + 32'(i * 32'h01010101),
                 32'h0, 1'b0, 1);
        for (int i = 0; i < 8; i++)
            send(1, M_XRD, MT_W, 32'(4 * i), 32'h0,
                 32'hA5000000 + 32'(i * 32'h01010101), 1'b0, i != 7);

        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
